edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
Multi-channel rising-edge event controller sitting between N asynchronous-to-logic (already synchronised) level signals and a single event consumer. Each channel runs its own rising-edge detector and holds one pending event. A round-robin arbiter serialises pending events onto one valid/ready event port, reporting the channel index. Events that arrive while a channel's previous event is still undelivered set a sticky per-channel overflow flag.

Parameters:
N_CH, 4, number of input channels (1..32)
CH_W, (N_CH>1)?$clog2(N_CH):1, width of channel index (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
signal_in  input  N_CH  per-channel level inputs, already synchronous to clk
enable  input  N_CH  per-channel edge-detect enable
evt_valid  output  1  event offered to consumer
evt_ready  input  1  consumer accepts event
evt_ch  output  CH_W  channel index of offered event
overflow  output  N_CH  sticky per-channel lost-event flag
overflow_clr  input  1  clear all overflow bits

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); all state updates on posedge clk.
- Reset values: prev=0, pending=0, overflow=0, evt_valid=0, evt_ch=0, state=IDLE, last_grant=N_CH-1 (channel 0 has first priority).
- Edge detect per channel: rise[i] = signal_in[i] & ~prev[i] & enable[i]. prev[i] <= signal_in[i] every cycle, regardless of enable.
- Because prev resets to 0, a signal_in high on the first cycle after reset counts as a rise.
- enable only masks new edges; already-pending events remain deliverable.
- pending[i]: set at the edge where rise[i]=1. Cleared at the edge where evt_valid & evt_ready & evt_ch==i.
- Simultaneous rise and accept on the same channel: pending stays 1, no overflow.
- overflow[i]: set when rise[i] & pending[i] & !(accept of channel i this cycle). Sticky.
- overflow_clr clears all bits; a set in the same cycle wins.
- FSM with two states:
  - IDLE: evt_valid=0. If any pending, pick the first pending channel searching last_grant+1, last_grant+2, ... (mod N_CH). Register evt_ch, assert evt_valid, go to OFFER.
  - OFFER: evt_valid=1; evt_ch and evt_valid held stable while !evt_ready.
  - On evt_ready in OFFER: clear pending[evt_ch], last_grant <= evt_ch, evt_valid <= 0, go to IDLE.
- Latency: signal_in sampled high at edge k (low at k-1) -> pending at k -> evt_valid high after edge k+1.
- Throughput: max one event per 2 cycles.
- evt_ready while evt_valid=0 is ignored.
- Reset mid-offer: at the reset edge evt_valid drops, all pending and overflow bits clear, and the in-flight event is discarded.
- N_CH=1: arbiter degenerates to a single channel; evt_ch is constant 0.

Decomposition:
- Package edge_evt_pkg:
  - state typedef (IDLE=1'b0, OFFER=1'b1)
  - function ch_width(n) returning the CH_W rule
  - round-robin search function next_grant(pending, last)
- Sub-module edge_capture (one instance per channel, generate loop): holds prev, pending and overflow for one channel.
  - Inputs: clk, rst, signal, enable, clr_pending, overflow_clr.
  - Outputs: pending, overflow.
- Top level contains only the arbiter FSM and the generate loop.

Test Plan:
- Reset/first edge: rst for 2 cycles with signal_in=4'b0000, then signal_in[2] 0->1 with evt_ready=1 -> evt_valid=1, evt_ch=2 exactly 2 edges after sampling; accepted next edge; overflow=0.
- Round-robin: all four channels rise in the same cycle, evt_ready=1 -> evt_ch sequence 0,1,2,3, one grant every 2 cycles; a second simultaneous burst then resumes from 0 after last_grant=3.
- Backpressure: channel 1 rises, evt_ready=0 for 5 cycles -> evt_valid and evt_ch=1 held stable; then evt_ready=1 -> accepted in one cycle; channel 3 rising during the stall is offered next.
- Overflow: channel 0 rises, evt_ready=0, signal_in[0] pulses 0->1 again -> overflow=4'b0001 sticky. overflow_clr=1 -> 0. overflow_clr coinciding with a new overflow event -> bit stays 1.
- Accept/rise collision and enable mask: channel 2 re-rises in the same cycle its event is accepted -> second event offered, no overflow. enable[3]=0 with signal_in[3] toggling -> no events on channel 3.
- Reset mid-offer: assert rst while evt_valid=1, evt_ch=1 with pending 4'b1010 -> the next cycle shows evt_valid=0, pending=0, overflow=0; no stale event after rst is released.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge event arbiter.
// Channel-width rule and round-robin grant search.
package edge_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of pend searching last+1, last+2, ... (mod n).
  function automatic logic [4:0] next_grant(
    input logic [31:0] pend,
    input logic [4:0]  last,
    input int          n
  );
    logic [5:0] idx;
    logic [4:0] res;
    logic       found;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      idx = {1'b0, last} + 6'(k);
      if (idx >= 6'(n)) idx = idx - 6'(n);
      if (k <= n && !found && pend[idx[4:0]]) begin
        res   = idx[4:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_capture.sv
// Per-channel rising-edge capture.
// Holds previous level, one pending event and a sticky overflow bit.
module edge_capture (
  input  logic clk,
  input  logic rst,
  input  logic signal,
  input  logic enable,
  input  logic clr_pending,
  input  logic overflow_clr,
  output logic pending,
  output logic overflow
);

  logic prev;
  logic rise;

  assign rise = signal & ~prev & enable;

  // Edge history, pending event and lost-event flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev <= signal;
      if (rise) pending <= 1'b1;
      else if (clr_pending) pending <= 1'b0;
      if (rise & pending & ~clr_pending) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event controller.
// Round-robin serialises pending channel events onto one valid/ready port.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_width(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] signal_in,
  input  logic [N_CH-1:0] enable,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic [N_CH-1:0] overflow,
  input  logic            overflow_clr
);

  state_t          state;
  state_t          state_next;
  logic [CH_W-1:0] ch_q;
  logic [CH_W-1:0] ch_next;
  logic [CH_W-1:0] last_q;
  logic [CH_W-1:0] last_next;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] clr_pending;

  // FSM state, offered channel and last granted channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ch_q   <= '0;
      last_q <= CH_W'(N_CH - 1);
    end else begin
      state  <= state_next;
      ch_q   <= ch_next;
      last_q <= last_next;
    end
  end

  // Grant selection, offer handshake and pending clear.
  always_comb begin
    state_next  = state;
    ch_next     = ch_q;
    last_next   = last_q;
    clr_pending = '0;
    evt_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          ch_next = CH_W'(next_grant(32'(pending),
                                     5'(last_q), N_CH));
          state_next = OFFER;
        end
      end
      OFFER: begin
        evt_valid = 1'b1;
        if (evt_ready) begin
          clr_pending[ch_q] = 1'b1;
          last_next         = ch_q;
          state_next        = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign evt_ch = ch_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_capture u_cap (
      .clk          (clk),
      .rst          (rst),
      .signal       (signal_in[i]),
      .enable       (enable[i]),
      .clr_pending  (clr_pending[i]),
      .overflow_clr (overflow_clr),
      .pending      (pending[i]),
      .overflow     (overflow[i])
    );
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter.
// Reference model plus grant scoreboard, directed and random stimulus.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] signal_in = '0;
  logic [N-1:0] enable = '1;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [1:0]   evt_ch;
  logic [N-1:0] overflow;
  logic         overflow_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_pend[N];
  bit m_ovf[N];
  bit m_prev[N];
  int m_last = N - 1;
  bit m_offer = 1'b0;
  int m_ch = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  edge_event_arbiter #(.N_CH(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .signal_in    (signal_in),
    .enable       (enable),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_ch       (evt_ch),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // Reference model: advances one clock using spec rules.
  always @(posedge clk) begin
    bit old_pend[N];
    bit acc;
    int acc_ch;
    bit rise;
    bit hit;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_ovf[i]  = 0;
        m_prev[i] = 0;
      end
      m_last  = N - 1;
      m_offer = 0;
      m_ch    = 0;
      exp_q.delete();
    end else begin
      old_pend = m_pend;
      acc      = m_offer && evt_ready;
      acc_ch   = m_ch;
      if (m_offer) begin
        if (evt_ready) begin
          m_offer = 0;
          m_last  = m_ch;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (old_pend[c]) begin
            m_offer = 1;
            m_ch    = c;
            exp_q.push_back(c);
            break;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        rise = signal_in[i] && !m_prev[i] && enable[i];
        hit  = acc && (acc_ch == i);
        if (rise && old_pend[i] && !hit) m_ovf[i] = 1;
        else if (overflow_clr) m_ovf[i] = 0;
        if (rise) m_pend[i] = 1;
        else if (hit) m_pend[i] = 0;
        m_prev[i] = signal_in[i];
      end
    end
  end

  // Monitor: per-cycle state checks and grant scoreboard.
  always @(negedge clk) begin
    logic [N-1:0] ovf_exp;
    int e;
    if (!rst) begin
      for (int i = 0; i < N; i++) ovf_exp[i] = m_ovf[i];
      n_cmp++;
      if (evt_valid !== m_offer) begin
        n_bad++;
        $display("FAIL evt_valid t=%0t got %b want %b",
                 $time, evt_valid, m_offer);
      end
      n_cmp++;
      if (overflow !== ovf_exp) begin
        n_bad++;
        $display("FAIL overflow t=%0t got %b want %b",
                 $time, overflow, ovf_exp);
      end
      if (evt_valid === 1'b1 && evt_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL grant t=%0t got ch %0d want none",
                   $time, evt_ch);
        end else begin
          e = exp_q.pop_front();
          if (int'(evt_ch) != e) begin
            n_bad++;
            $display("FAIL grant t=%0t got ch %0d want %0d",
                     $time, evt_ch, e);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_ovf(input string nm,
                         input logic [N-1:0] want);
    n_cmp++;
    if (overflow !== want) begin
      n_bad++;
      $display("FAIL %s got %b want %b", nm, overflow, want);
    end
  endtask

  initial begin
    // Reset and first edge on channel 2.
    step(2);
    rst = 1'b0;
    evt_ready = 1'b1;
    signal_in = 4'b0100;
    step(5);
    chk_ovf("first_edge_ovf", 4'b0000);
    signal_in = '0;
    step(2);

    // Simultaneous bursts: round-robin order.
    signal_in = 4'b1111;
    step(1);
    signal_in = '0;
    step(10);
    signal_in = 4'b1111;
    step(1);
    signal_in = '0;
    step(10);

    // Backpressure with a second channel rising.
    evt_ready = 1'b0;
    signal_in = 4'b0010;
    step(2);
    signal_in = 4'b1010;
    step(5);
    evt_ready = 1'b1;
    step(6);
    signal_in = '0;
    step(2);

    // Overflow, clear, and clear colliding with set.
    evt_ready = 1'b0;
    signal_in = 4'b0001;
    step(2);
    signal_in = 4'b0000;
    step(1);
    signal_in = 4'b0001;
    step(2);
    chk_ovf("ovf_set", 4'b0001);
    step(2);
    chk_ovf("ovf_sticky", 4'b0001);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    chk_ovf("ovf_clr", 4'b0000);
    signal_in = 4'b0000;
    step(1);
    signal_in = 4'b0001;
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    chk_ovf("ovf_set_wins", 4'b0001);
    evt_ready = 1'b1;
    signal_in = '0;
    step(4);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;

    // Accept and re-rise on channel 2 in one cycle.
    evt_ready = 1'b0;
    signal_in = 4'b0100;
    step(2);
    signal_in = 4'b0000;
    step(1);
    signal_in = 4'b0100;
    evt_ready = 1'b1;
    step(1);
    step(4);
    chk_ovf("collision_ovf", 4'b0000);
    signal_in = '0;

    // Enable mask on channel 3.
    enable = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      signal_in[3] = ~signal_in[3];
      step(1);
    end
    signal_in = '0;
    step(1);
    enable = 4'b1111;
    step(3);

    // Reset while an offer is outstanding.
    evt_ready = 1'b0;
    signal_in = 4'b1010;
    step(4);
    rst = 1'b1;
    signal_in = '0;
    step(1);
    rst = 1'b0;
    chk_ovf("rst_ovf", 4'b0000);
    evt_ready = 1'b1;
    step(6);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) signal_in[i] = ~signal_in[i];
      enable = ($urandom_range(7) == 0) ? 4'($urandom) : 4'hf;
      evt_ready = 1'($urandom_range(1));
      overflow_clr = ($urandom_range(19) == 0);
      rst = ($urandom_range(199) == 0);
      step(1);
    end

    // Drain.
    rst = 1'b0;
    overflow_clr = 1'b0;
    signal_in = '0;
    evt_ready = 1'b1;
    step(12);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
